// File: rtl/rx_frame_pkg.sv
// rtl/rx_frame_pkg.sv - shared state encodings and counter-width helper for rx_frame_interface
//
// Purpose: constants shared by the receive front end and the result serializer.
//   ST_*       : FSM state encodings, also exported on o_state for LED debug
//   cnt_width  : register width for a counter that must hold 0..n-1 (minimum 1 bit)
package rx_frame_pkg;

    localparam logic [2:0] ST_RECV_OPND  = 3'd0;
    localparam logic [2:0] ST_RECV_OPC   = 3'd1;
    localparam logic [2:0] ST_EXEC       = 3'd2;
    localparam logic [2:0] ST_SEND_START = 3'd3;
    localparam logic [2:0] ST_SEND_WAIT  = 3'd4;

    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tx_result_serializer.sv
// rtl/tx_result_serializer.sv - latches the ALU result and hands it to UART TX byte by byte
//
// Purpose: EXEC / SEND_START / SEND_WAIT sequencing, result shift register, byte counter.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   commit_i       : one-cycle pulse, a frame was committed on this edge
//   alu_result_i   : combinational ALU result, sampled in EXEC
//   tx_done_i      : one-cycle strobe, TX finished the current byte (only honoured in SEND_WAIT)
//   state_o        : serializer state (ST_RECV_OPND doubles as idle)
//   busy_o         : high from commit until the last tx_done_i
//   start_tx_o     : one-cycle pulse in the first SEND_WAIT cycle of each byte
//   data_o         : byte currently offered to TX
module tx_result_serializer
    import rx_frame_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int RESULT_BYTES = 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              commit_i,
    input  logic [RESULT_BYTES*DATA_BITS-1:0] alu_result_i,
    input  logic                              tx_done_i,
    output logic [2:0]                        state_o,
    output logic                              busy_o,
    output logic                              start_tx_o,
    output logic [DATA_BITS-1:0]              data_o
);

    localparam int RW = RESULT_BYTES * DATA_BITS;
    localparam int CW = cnt_width(RESULT_BYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(RESULT_BYTES - 1);

    logic [2:0]           state_q, state_d;
    logic [RW-1:0]        sr_q, sr_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 start_tx_q, start_tx_d;
    logic [DATA_BITS-1:0] data_q, data_d;

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        start_tx_d = 1'b0;
        case (state_q)
            ST_RECV_OPND: begin
                if (commit_i) begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // The committed operands reached the ALU one cycle ago, so its output is stable now.
                sr_d    = alu_result_i;
                data_d  = alu_result_i[DATA_BITS-1:0];
                cnt_d   = '0;
                state_d = ST_SEND_START;
            end
            ST_SEND_START: begin
                // Registered so the pulse lands in the cycle after SEND_START, together with SEND_WAIT.
                start_tx_d = 1'b1;
                state_d    = ST_SEND_WAIT;
            end
            ST_SEND_WAIT: begin
                if (tx_done_i) begin
                    if (cnt_q != CNT_LAST) begin
                        sr_d    = sr_q >> DATA_BITS;
                        data_d  = sr_d[DATA_BITS-1:0];
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ST_SEND_START;
                    end else begin
                        state_d = ST_RECV_OPND;
                    end
                end
            end
            default: begin
                state_d = ST_RECV_OPND;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RECV_OPND;
            sr_q       <= '0;
            cnt_q      <= '0;
            start_tx_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            start_tx_q <= start_tx_d;
            data_q     <= data_d;
        end
    end

    assign state_o    = state_q;
    assign busy_o     = (state_q != ST_RECV_OPND);
    assign start_tx_o = start_tx_q;
    assign data_o     = data_q;

endmodule

// File: rtl/rx_frame_interface.sv
// rtl/rx_frame_interface.sv - UART RX frame assembler and ALU front end with timeout and overrun
//
// Purpose: collects NUM_OPERANDS operand bytes plus one opcode byte, commits them atomically
// to the ALU, then lets tx_result_serializer return the result over UART TX.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   i_data_ready     : one-cycle strobe, i_data holds a received byte
//   i_data           : received byte
//   i_alu_result     : combinational ALU result
//   i_tx_done        : one-cycle strobe, TX finished the current byte
//   o_operands       : committed operands, operand k at [k*DATA_BITS +: DATA_BITS]
//   o_opcode         : committed opcode (low OPCODE_BITS of the opcode byte)
//   o_alu_valid      : one-cycle pulse after each commit
//   o_start_tx       : one-cycle pulse, start TX of o_data
//   o_data           : byte offered to TX
//   o_busy           : high from commit until the last i_tx_done
//   o_frame_error    : one-cycle pulse when a partial frame is discarded on timeout
//   o_overrun        : one-cycle pulse when a byte arrives while busy (byte dropped)
//   o_state          : current FSM state for LED debug
module rx_frame_interface
    import rx_frame_pkg::*;
#(
    parameter int DATA_BITS      = 8,
    parameter int NUM_OPERANDS   = 2,
    parameter int OPCODE_BITS    = 6,
    parameter int RESULT_BYTES   = 1,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                              i_clock,
    input  logic                              i_reset,
    input  logic                              i_data_ready,
    input  logic [DATA_BITS-1:0]              i_data,
    input  logic [RESULT_BYTES*DATA_BITS-1:0] i_alu_result,
    input  logic                              i_tx_done,
    output logic [NUM_OPERANDS*DATA_BITS-1:0] o_operands,
    output logic [OPCODE_BITS-1:0]            o_opcode,
    output logic                              o_alu_valid,
    output logic                              o_start_tx,
    output logic [DATA_BITS-1:0]              o_data,
    output logic                              o_busy,
    output logic                              o_frame_error,
    output logic                              o_overrun,
    output logic [2:0]                        o_state
);

    localparam int OW = NUM_OPERANDS * DATA_BITS;
    localparam int IW = cnt_width(NUM_OPERANDS);
    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_OPERANDS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [2:0]             rx_state_q, rx_state_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [OW-1:0]          shadow_q, shadow_d;
    logic [OW-1:0]          operands_q, operands_d;
    logic [OPCODE_BITS-1:0] opcode_q, opcode_d;
    logic                   alu_valid_q, alu_valid_d;
    logic                   frame_error_q, frame_error_d;
    logic                   overrun_q, overrun_d;
    logic                   partial;
    logic                   commit;
    logic                   ser_busy;
    logic [2:0]             ser_state;

    always_comb begin
        rx_state_d    = rx_state_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        shadow_d      = shadow_q;
        operands_d    = operands_q;
        opcode_d      = opcode_q;
        alu_valid_d   = 1'b0;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;
        commit        = 1'b0;
        partial       = 1'b0;

        if (ser_busy) begin
            // A result is in flight: incoming bytes are dropped and flagged, frame state untouched.
            overrun_d = i_data_ready;
            tmo_d     = '0;
        end else begin
            case (rx_state_q)
                ST_RECV_OPND: begin
                    if (i_data_ready) begin
                        for (int k = 0; k < NUM_OPERANDS; k++) begin
                            if (idx_q == IW'(k)) begin
                                shadow_d[k*DATA_BITS +: DATA_BITS] = i_data;
                            end
                        end
                        if (idx_q == IDX_LAST) begin
                            idx_d      = '0;
                            rx_state_d = ST_RECV_OPC;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                ST_RECV_OPC: begin
                    if (i_data_ready) begin
                        operands_d  = shadow_q;
                        opcode_d    = i_data[OPCODE_BITS-1:0];
                        alu_valid_d = 1'b1;
                        commit      = 1'b1;
                        rx_state_d  = ST_RECV_OPND;
                    end
                end
                default: begin
                    rx_state_d = ST_RECV_OPND;
                end
            endcase

            partial = (rx_state_q == ST_RECV_OPC) || (idx_q != '0);

            // A byte arriving on the expiry cycle wins over the timeout.
            if (i_data_ready || (rx_state_d != rx_state_q) || !partial || (TIMEOUT_CYCLES == 0)) begin
                tmo_d = '0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d         = '0;
                idx_d         = '0;
                rx_state_d    = ST_RECV_OPND;
                frame_error_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            rx_state_q    <= ST_RECV_OPND;
            idx_q         <= '0;
            tmo_q         <= '0;
            shadow_q      <= '0;
            operands_q    <= '0;
            opcode_q      <= '0;
            alu_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            rx_state_q    <= rx_state_d;
            idx_q         <= idx_d;
            tmo_q         <= tmo_d;
            shadow_q      <= shadow_d;
            operands_q    <= operands_d;
            opcode_q      <= opcode_d;
            alu_valid_q   <= alu_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    tx_result_serializer #(
        .DATA_BITS    (DATA_BITS),
        .RESULT_BYTES (RESULT_BYTES)
    ) u_tx_result_serializer (
        .clk_i        (i_clock),
        .rst_i        (i_reset),
        .commit_i     (commit),
        .alu_result_i (i_alu_result),
        .tx_done_i    (i_tx_done),
        .state_o      (ser_state),
        .busy_o       (ser_busy),
        .start_tx_o   (o_start_tx),
        .data_o       (o_data)
    );

    assign o_operands    = operands_q;
    assign o_opcode      = opcode_q;
    assign o_alu_valid   = alu_valid_q;
    assign o_busy        = ser_busy;
    assign o_frame_error = frame_error_q;
    assign o_overrun     = overrun_q;
    // The receive FSM is parked in RECV_OPND while the serializer owns the frame.
    assign o_state       = ser_busy ? ser_state : rx_state_q;

endmodule

// File: tb/tb_rx_frame_interface.sv
// tb/tb_rx_frame_interface.sv - self-checking bench for rx_frame_interface
module tb_rx_frame_interface;

    localparam int DATA_BITS      = 8;
    localparam int NUM_OPERANDS   = 2;
    localparam int OPCODE_BITS    = 6;
    localparam int RESULT_BYTES   = 2;
    localparam int TIMEOUT_CYCLES = 10;

    logic        i_clock      = 1'b0;
    logic        i_reset      = 1'b1;
    logic        i_data_ready = 1'b0;
    logic [7:0]  i_data       = 8'h00;
    logic        i_tx_done    = 1'b0;
    logic [15:0] i_alu_result;
    logic [15:0] o_operands;
    logic [5:0]  o_opcode;
    logic        o_alu_valid;
    logic        o_start_tx;
    logic [7:0]  o_data;
    logic        o_busy;
    logic        o_frame_error;
    logic        o_overrun;
    logic [2:0]  o_state;

    logic        use_fixed    = 1'b1;
    logic [15:0] fixed_result = 16'h0000;

    int vectors     = 0;
    int miscompares = 0;
    int fe_cnt      = 0;
    int ov_cnt      = 0;
    int av_cnt      = 0;
    int st_cnt      = 0;

    always #5 i_clock = ~i_clock;

    // Bench-side ALU: result bytes derived from the committed frame.
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [5:0] opc);
        alu_f = {b ^ {2'b00, opc}, a + b};
    endfunction

    assign i_alu_result = use_fixed ? fixed_result : alu_f(o_operands[7:0], o_operands[15:8], o_opcode);

    rx_frame_interface #(
        .DATA_BITS      (DATA_BITS),
        .NUM_OPERANDS   (NUM_OPERANDS),
        .OPCODE_BITS    (OPCODE_BITS),
        .RESULT_BYTES   (RESULT_BYTES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .i_clock       (i_clock),
        .i_reset       (i_reset),
        .i_data_ready  (i_data_ready),
        .i_data        (i_data),
        .i_alu_result  (i_alu_result),
        .i_tx_done     (i_tx_done),
        .o_operands    (o_operands),
        .o_opcode      (o_opcode),
        .o_alu_valid   (o_alu_valid),
        .o_start_tx    (o_start_tx),
        .o_data        (o_data),
        .o_busy        (o_busy),
        .o_frame_error (o_frame_error),
        .o_overrun     (o_overrun),
        .o_state       (o_state)
    );

    always @(negedge i_clock) begin
        if (!i_reset) begin
            if (o_frame_error) fe_cnt <= fe_cnt + 1;
            if (o_overrun)     ov_cnt <= ov_cnt + 1;
            if (o_alu_valid)   av_cnt <= av_cnt + 1;
            if (o_start_tx)    st_cnt <= st_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] value);
        i_data       = value;
        i_data_ready = 1'b1;
        tick();
        i_data_ready = 1'b0;
    endtask

    task automatic pulse_done();
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!o_start_tx && n < 20) begin
            tick();
            n++;
        end
        check("start_tx_seen", 32'(o_start_tx), 1);
    endtask

    task automatic serve_tx(input logic [15:0] exp, input bit stray);
        logic [7:0] byte_exp;
        for (int b = 0; b < RESULT_BYTES; b++) begin
            wait_start();
            byte_exp = exp[b*8 +: 8];
            check("tx_byte", 32'(o_data), 32'(byte_exp));
            if (stray && b == 0) begin
                send_byte(8'($urandom));
                check("overrun_pulse", 32'(o_overrun), 1);
                check("overrun_state", 32'(o_state), 4);
            end
            repeat ($urandom_range(0, 3)) tick();
            pulse_done();
        end
        check("busy_cleared", 32'(o_busy), 0);
        check("idle_state", 32'(o_state), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int exp_fe;
        int exp_ov;
        int commits;
        int av_base;
        int st_base;

        repeat (3) tick();
        i_reset = 1'b0;

        // Reset state
        check("rst_state", 32'(o_state), 0);
        check("rst_operands", 32'(o_operands), 0);
        check("rst_opcode", 32'(o_opcode), 0);
        check("rst_data", 32'(o_data), 0);
        check("rst_busy", 32'(o_busy), 0);
        check("rst_pulses", 32'({o_alu_valid, o_start_tx, o_frame_error, o_overrun}), 0);

        // Basic frame with latency checks
        fixed_result = 16'h0008;
        send_byte(8'h05);
        send_byte(8'h03);
        send_byte(8'h20);
        check("t1_alu_valid", 32'(o_alu_valid), 1);
        check("t1_operands", 32'(o_operands), 32'h0305);
        check("t1_opcode", 32'(o_opcode), 32'h20);
        check("t1_busy", 32'(o_busy), 1);
        check("t1_state_exec", 32'(o_state), 2);
        tick();
        check("t1_alu_valid_once", 32'(o_alu_valid), 0);
        check("t1_no_early_start", 32'(o_start_tx), 0);
        check("t1_data_loaded", 32'(o_data), 32'h08);
        tick();
        check("t1_start_tx", 32'(o_start_tx), 1);
        check("t1_start_data", 32'(o_data), 32'h08);
        check("t1_state_wait", 32'(o_state), 4);
        tick();
        check("t1_start_once", 32'(o_start_tx), 0);
        pulse_done();
        check("t1_second_data", 32'(o_data), 32'h00);
        check("t1_still_busy", 32'(o_busy), 1);
        wait_start();
        pulse_done();
        check("t1_busy_done", 32'(o_busy), 0);
        check("t1_av_count", av_cnt, 1);

        // Two result bytes, LSB first, and no third start
        fixed_result = 16'hBEEF;
        st_base = st_cnt;
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h01);
        check("t2_operands", 32'(o_operands), 32'h3412);
        serve_tx(16'hBEEF, 1'b0);
        repeat (5) tick();
        check("t2_start_count", st_cnt - st_base, 2);

        // Timeout discards a partial frame, committed outputs kept
        use_fixed = 1'b0;
        send_byte(8'h11);
        repeat (9) tick();
        check("t3_no_early_error", 32'(o_frame_error), 0);
        tick();
        check("t3_frame_error", 32'(o_frame_error), 1);
        check("t3_operands_kept", 32'(o_operands), 32'h3412);
        check("t3_state", 32'(o_state), 0);
        tick();
        check("t3_error_once", 32'(o_frame_error), 0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("t3_operands", 32'(o_operands), 32'h0201);
        check("t3_opcode", 32'(o_opcode), 32'h03);
        serve_tx(alu_f(8'h01, 8'h02, 6'h03), 1'b0);

        // A byte coinciding with expiry is accepted
        exp_fe = fe_cnt;
        send_byte(8'h44);
        repeat (9) tick();
        send_byte(8'h55);
        check("t6_no_error", 32'(o_frame_error), 0);
        check("t6_state_opc", 32'(o_state), 1);
        send_byte(8'hFF);
        check("t6_operands", 32'(o_operands), 32'h5544);
        check("t6_opcode", 32'(o_opcode), 32'h3F);
        check("t6_err_count", fe_cnt, exp_fe);
        serve_tx(alu_f(8'h44, 8'h55, 6'h3F), 1'b0);

        // Overrun while sending, then a clean frame
        send_byte(8'h21);
        send_byte(8'h43);
        send_byte(8'h05);
        serve_tx(alu_f(8'h21, 8'h43, 6'h05), 1'b1);
        send_byte(8'h66);
        send_byte(8'h77);
        send_byte(8'h08);
        check("t4_operands", 32'(o_operands), 32'h7766);
        check("t4_opcode", 32'(o_opcode), 32'h08);
        serve_tx(alu_f(8'h66, 8'h77, 6'h08), 1'b0);

        // Reset in SEND_WAIT
        send_byte(8'h0A);
        send_byte(8'h0B);
        send_byte(8'h0C);
        wait_start();
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("t5_state", 32'(o_state), 0);
        check("t5_busy", 32'(o_busy), 0);
        check("t5_start", 32'(o_start_tx), 0);
        check("t5_outputs", 32'({o_operands, o_opcode, o_data}), 0);
        check("t5_pulses", 32'({o_alu_valid, o_frame_error, o_overrun}), 0);
        pulse_done();
        check("t5_done_ignored_state", 32'(o_state), 0);
        tick();
        check("t5_done_ignored_start", 32'(o_start_tx), 0);
        check("t5_done_ignored_busy", 32'(o_busy), 0);

        // Randomized frames against a byte-queue model
        exp_fe  = fe_cnt;
        exp_ov  = ov_cnt;
        av_base = av_cnt;
        commits = 0;
        for (int i = 0; i < 150; i++) begin
            int g;
            logic [7:0] v;
            bit stray;
            g = ($urandom_range(0, 5) == 0) ? int'($urandom_range(8, 12)) : int'($urandom_range(0, 3));
            repeat (g) tick();
            if (q.size() > 0 && g >= TIMEOUT_CYCLES) begin
                exp_fe++;
                q.delete();
            end
            v = 8'($urandom);
            send_byte(v);
            q.push_back(v);
            if (q.size() == NUM_OPERANDS + 1) begin
                commits++;
                check("rand_alu_valid", 32'(o_alu_valid), 1);
                check("rand_operands", 32'(o_operands), 32'({q[1], q[0]}));
                check("rand_opcode", 32'(o_opcode), 32'(q[2][5:0]));
                check("rand_frame_errors", fe_cnt, exp_fe);
                stray = ($urandom_range(0, 3) == 0);
                if (stray) exp_ov++;
                serve_tx(alu_f(q[0], q[1], q[2][5:0]), stray);
                q.delete();
            end
        end
        repeat (2) tick();
        check("rand_total_errors", fe_cnt, exp_fe);
        check("rand_total_overruns", ov_cnt, exp_ov);
        check("rand_total_commits", av_cnt - av_base, commits);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
